// File: rtl/matvec_param.sv
// Streaming signed matrix-vector multiplier: y = W*x, one output row per handshake.
// A loaded matrix is kept and reused by later vector-only transactions.
module matvec_param #(
    parameter int unsigned M     = 8,
    parameter int unsigned N     = 8,
    parameter int unsigned IN_W  = 14,
    parameter int unsigned OUT_W = 2 * IN_W + $clog2(N),
    parameter bit          RELU  = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    input_valid,
    output logic                    input_ready,
    input  logic signed [IN_W-1:0]  input_data,
    input  logic                    new_matrix,
    output logic                    output_valid,
    input  logic                    output_ready,
    output logic signed [OUT_W-1:0] output_data
);

    localparam int unsigned WN     = M * N;
    localparam int unsigned WIDX_W = $clog2(WN);
    localparam int unsigned XIDX_W = $clog2(N);
    localparam int unsigned ROW_W  = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned STEP_W = $clog2(N + 2);
    localparam int unsigned PROD_W = 2 * IN_W;

    typedef enum logic [2:0] {StIdle, StLoadW, StLoadX, StCompute, StOut} state_e;

    state_e state;

    logic signed [IN_W-1:0]   w_mem [WN];
    logic signed [IN_W-1:0]   x_mem [N];

    logic [WIDX_W-1:0]        w_idx;
    logic [WIDX_W-1:0]        w_base;
    logic [XIDX_W-1:0]        x_idx;
    logic [ROW_W-1:0]         row;
    logic [STEP_W-1:0]        step;
    logic                     matrix_loaded;
    logic signed [PROD_W-1:0] prod;
    logic signed [OUT_W-1:0]  acc;

    logic [WIDX_W-1:0]        w_rd;
    logic signed [PROD_W-1:0] w_ext;
    logic signed [PROD_W-1:0] x_ext;
    logic signed [OUT_W-1:0]  result;

    // Reads beyond column N-1 happen while step sweeps past the row; their value is unused.
    always_comb begin
        w_rd   = w_base + WIDX_W'(step);
        w_ext  = PROD_W'(w_mem[w_rd]);
        x_ext  = PROD_W'(x_mem[XIDX_W'(step)]);
        result = acc;
        if (!matrix_loaded || (RELU && acc[OUT_W-1])) begin
            result = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= StIdle;
            input_ready   <= 1'b0;
            output_valid  <= 1'b0;
            output_data   <= '0;
            matrix_loaded <= 1'b0;
            w_idx         <= '0;
            w_base        <= '0;
            x_idx         <= '0;
            row           <= '0;
            step          <= '0;
            prod          <= '0;
            acc           <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    input_ready <= 1'b1;
                    if (input_valid && input_ready) begin
                        if (new_matrix) begin
                            w_mem[0] <= input_data;
                            w_idx    <= WIDX_W'(1);
                            state    <= StLoadW;
                        end else begin
                            x_mem[0] <= input_data;
                            x_idx    <= XIDX_W'(1);
                            state    <= StLoadX;
                        end
                    end
                end
                StLoadW: begin
                    if (input_valid && input_ready) begin
                        w_mem[w_idx] <= input_data;
                        if (w_idx == WIDX_W'(WN - 1)) begin
                            matrix_loaded <= 1'b1;
                            x_idx         <= '0;
                            state         <= StLoadX;
                        end else begin
                            w_idx <= w_idx + 1'b1;
                        end
                    end
                end
                StLoadX: begin
                    if (input_valid && input_ready) begin
                        x_mem[x_idx] <= input_data;
                        if (x_idx == XIDX_W'(N - 1)) begin
                            input_ready <= 1'b0;
                            row         <= '0;
                            w_base      <= '0;
                            step        <= '0;
                            state       <= StCompute;
                        end else begin
                            x_idx <= x_idx + 1'b1;
                        end
                    end
                end
                StCompute: begin
                    // Multiply stage runs one step ahead of the accumulate stage.
                    if (step < STEP_W'(N)) begin
                        prod <= w_ext * x_ext;
                    end
                    if (step == STEP_W'(1)) begin
                        acc <= OUT_W'(prod);
                    end else if (step != '0 && step <= STEP_W'(N)) begin
                        acc <= acc + OUT_W'(prod);
                    end
                    if (step == STEP_W'(N + 1)) begin
                        output_data  <= result;
                        output_valid <= 1'b1;
                        state        <= StOut;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                StOut: begin
                    if (output_ready) begin
                        output_valid <= 1'b0;
                        if (row == ROW_W'(M - 1)) begin
                            row         <= '0;
                            input_ready <= 1'b1;
                            state       <= StIdle;
                        end else begin
                            row    <= row + 1'b1;
                            w_base <= w_base + WIDX_W'(N);
                            step   <= '0;
                            state  <= StCompute;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/matvec_param.md
Name: matvec_param

Overview:
- Parametrised streaming matrix-vector multiplier, successor to the fixed 8x8 / 14-bit matrix-vector unit. Computes y = W·x for an M×N signed matrix W and an N-element signed vector x.
- Operands arrive on one valid/ready input stream. A stored matrix is reused across vectors until a new one is loaded.
- Results leave one row at a time on a valid/ready output stream.
- Adds over the previous generation: parametrised dimensions and widths, output backpressure between rows, a matrix-present flag, and optional ReLU output clamping.

Parameters:
- M, 8, number of matrix rows = number of output words per vector (≥1).
- N, 8, number of matrix columns = vector length (≥2).
- IN_W, 14, signed input element width.
- OUT_W, 2*IN_W+$clog2(N), signed result/accumulator width; sized so overflow is impossible.
- RELU, 0, when 1, negative results are output as 0.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- input_valid  input  1  input word present.
- input_ready  output  1  block can accept an input word.
- input_data  input  IN_W  signed matrix or vector element.
- new_matrix  input  1  sampled on the first word of a transaction; 1 = matrix load precedes the vector.
- output_valid  output  1  output_data holds a result.
- output_ready  input  1  downstream accepts the result.
- output_data  output  OUT_W  signed result for the current row.

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high.
  - While reset is high: input_ready=0, output_valid=0, output_data=0, state=IDLE, matrix_loaded=0, all counters 0.
  - Weight and vector storage are not cleared.
  - Reset mid-transaction aborts it: partial loads are discarded and matrix_loaded is cleared.
- Input handshake: a word transfers on a rising edge with input_valid&&input_ready.
  - input_ready=1 only in IDLE, LOAD_W and LOAD_X; it is registered, not combinational from input_valid.
- States:
  - IDLE: input_ready=1.
    - On the first transfer with new_matrix=1: store the word as W[0][0] and go to LOAD_W.
    - On the first transfer with new_matrix=0: store the word as x[0] and go to LOAD_X.
  - LOAD_W: accepts the remaining M*N-1 weights in row-major order (W[r][c], c fastest). After W[M-1][N-1]: set matrix_loaded=1 and go to LOAD_X.
  - LOAD_X: accepts x[0..N-1], or x[1..N-1] if entered from IDLE with new_matrix=0. After x[N-1], go to COMPUTE with row=0.
  - COMPUTE: one multiply-accumulate per cycle over columns 0..N-1 of the current row. The product is registered before accumulation. Then go to OUT.
  - OUT: output_valid=1 with output_data stable until output_valid&&output_ready.
    - On the transfer: if row<M-1, increment row and return to COMPUTE; else go to IDLE.
- new_matrix is ignored on all transfers except the first of a transaction.
- Idle input_valid: gaps in input_valid during LOAD_W/LOAD_X only stall the load. Element indices advance on transfers only.
- Latency: output_valid for row r rises exactly N+2 cycles after the clock edge that completes the last vector transfer (r=0), or the row r-1 output transfer (r>0).
- Back-to-back transactions: the first cycle after the final output transfer is IDLE, with input_ready=1.
- Arithmetic:
  - Products are full-precision signed IN_W×IN_W.
  - The accumulator is OUT_W bits, signed, with no saturation needed.
  - If matrix_loaded=0 (no matrix since reset), results are 0.
  - RELU=1: a result with MSB=1 is output as 0. RELU=0: passthrough.
- Held outputs: output_data holds its last driven value when output_valid=0. Its value outside OUT is not checked.

Test Plan:
- Identity load and vector: defaults, new_matrix=1, W=I8, then x=1..8, output_ready=1 -> outputs 1,2,...,8; first output_valid 10 cycles after the x[7] transfer.
- Matrix reuse: after the identity test, send x=-3 for all 8 elements with new_matrix=0 on the first word -> eight outputs of -3. Repeat with RELU=1 -> eight outputs of 0.
- Extremes: all W=-8192 and all x=-8192 (IN_W=14 minimum) -> every output = 8·2^26 = 536870912 with no overflow. W=8191, x=-8192 -> every output = -536805376.
- Backpressure and gaps:
  - Hold output_ready=0 for 5 cycles on row 3 -> output_data stable and output_valid high throughout; row 4 appears N+2 cycles after release.
  - Random input_valid gaps -> identical results.
- Reset mid-operation: assert reset for 1 cycle after 20 weight words -> outputs idle and input_ready=0 during reset, input_ready=1 next cycle.
  - A following new_matrix=0 transaction then yields all-zero outputs.
  - A full reload yields correct results.
- Non-square parameters: M=3, N=5, IN_W=8, W[r][c]=r+c, x=1..5 -> outputs 40,55,70; output_valid is never high for a fourth row.
